// File: rtl/rv32_m_arbiter_pkg.sv
// Purpose: shared types and constants for the M-extension arbiter slice.
// Latency: none (declarations only).
// Backpressure: n/a.
package rv32_m_arbiter_pkg;

    localparam int XLEN        = 32;
    // Widest tag the request record can carry; the top truncates to its TAG_W.
    localparam int M_TAG_MAX_W = 16;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } m_arb_state_e;

    typedef struct packed {
        logic [2:0]             op;
        logic [XLEN-1:0]        a;
        logic [XLEN-1:0]        b;
        logic [M_TAG_MAX_W-1:0] tag;
        logic                   src;
    } m_req_t;

endpackage

// File: rtl/rv32_m_arbiter_if.sv
// Purpose: two-requester valid/ready request bus plus tagged response channel.
// Latency: none (wiring only).
// Backpressure: requesters hold valid until ready; consumer stalls the response via rsp_ready.
interface rv32_m_arbiter_if
    import rv32_m_arbiter_pkg::*;
#(
    parameter int TAG_W = 5
) ();

    logic              req0_valid;
    logic              req0_ready;
    logic [2:0]        req0_op;
    logic [XLEN-1:0]   req0_a;
    logic [XLEN-1:0]   req0_b;
    logic [TAG_W-1:0]  req0_tag;

    logic              req1_valid;
    logic              req1_ready;
    logic [2:0]        req1_op;
    logic [XLEN-1:0]   req1_a;
    logic [XLEN-1:0]   req1_b;
    logic [TAG_W-1:0]  req1_tag;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_data;
    logic              rsp_src;
    logic [TAG_W-1:0]  rsp_tag;

    // Requesters and the response consumer.
    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_tag,
        output req1_valid, req1_op, req1_a, req1_b, req1_tag,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_src, rsp_tag
    );

    // The arbiter.
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
        input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_src, rsp_tag
    );

endinterface

// File: rtl/rv32_m_arbiter_mext.sv
// Purpose: combinational RV32 M-extension datapath (MUL*/DIV*/REM*), RISC-V edge cases included.
// Latency: combinational; meant to be constrained as a multicycle path by its caller.
// Backpressure: none; output forced to zero when i_valid is low.
module rv32_m_extension
    import rv32_m_arbiter_pkg::*;
(
    input  logic             i_valid,
    input  logic [2:0]       i_op,
    input  logic [XLEN-1:0]  i_a,
    input  logic [XLEN-1:0]  i_b,
    output logic [XLEN-1:0]  o_result
);

    logic                   w_a_sgn;
    logic                   w_b_sgn;
    logic [2*XLEN-1:0]      w_a_ext;
    logic [2*XLEN-1:0]      w_b_ext;
    logic [2*XLEN-1:0]      w_prod;
    logic                   w_b_zero;
    logic                   w_ovf;
    logic [XLEN-1:0]        w_bs_safe;
    logic [XLEN-1:0]        w_bu_safe;
    logic [XLEN-1:0]        w_quot_s;
    logic [XLEN-1:0]        w_rem_s;
    logic [XLEN-1:0]        w_quot_u;
    logic [XLEN-1:0]        w_rem_u;
    logic [XLEN-1:0]        w_res;

    // One 64-bit multiplier serves all four MUL variants via operand extension.
    assign w_a_sgn = ((i_op == M_MULH) || (i_op == M_MULHSU)) & i_a[XLEN-1];
    assign w_b_sgn = (i_op == M_MULH) & i_b[XLEN-1];
    assign w_a_ext = {{XLEN{w_a_sgn}}, i_a};
    assign w_b_ext = {{XLEN{w_b_sgn}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Divisors are steered to 1 in the special cases so the dividers never see
    // a zero divisor or the signed overflow pair; the real result is muxed below.
    assign w_b_zero  = (i_b == '0);
    assign w_ovf     = (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == {XLEN{1'b1}});
    assign w_bs_safe = (w_b_zero | w_ovf) ? XLEN'(1) : i_b;
    assign w_bu_safe = w_b_zero ? XLEN'(1) : i_b;

    assign w_quot_s = XLEN'($signed(i_a) / $signed(w_bs_safe));
    assign w_rem_s  = XLEN'($signed(i_a) % $signed(w_bs_safe));
    assign w_quot_u = i_a / w_bu_safe;
    assign w_rem_u  = i_a % w_bu_safe;

    // Result select per funct3, with divide-by-zero results per the ISA.
    always_comb begin
        w_res = '0;
        case (i_op)
            M_MUL:    w_res = w_prod[XLEN-1:0];
            M_MULH,
            M_MULHSU,
            M_MULHU:  w_res = w_prod[2*XLEN-1:XLEN];
            M_DIV:    w_res = w_b_zero ? {XLEN{1'b1}} : w_quot_s;
            M_DIVU:   w_res = w_b_zero ? {XLEN{1'b1}} : w_quot_u;
            M_REM:    w_res = w_b_zero ? i_a : w_rem_s;
            M_REMU:   w_res = w_b_zero ? i_a : w_rem_u;
            default:  w_res = '0;
        endcase
    end

    assign o_result = i_valid ? w_res : '0;

endmodule

// File: rtl/rv32_m_arbiter.sv
// Purpose: round-robin arbiter/sequencer sharing one M unit between two requesters (option: RV32_M_DIV_EARLY_OUT_EN).
// Latency: accept in cycle t, rsp_valid from t+LAT+1 (LAT = MUL_CYCLES or DIV_CYCLES, 1 for early-out divides).
// Backpressure: ready only in IDLE; response held until rsp_ready; one bubble cycle after each response.
module rv32_m_arbiter
    import rv32_m_arbiter_pkg::*;
#(
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 4,
    parameter int TAG_W      = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    output logic                busy,
    rv32_m_arbiter_if.slave     bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_EXEC = EXEC;
    localparam logic [1:0] ST_RESP = RESP;

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rr_ptr;
    m_req_t            r_req;
    logic [XLEN-1:0]   r_rsp_data;
    logic              r_rsp_src;
    logic [TAG_W-1:0]  r_rsp_tag;

    logic              w_can_grant;
    logic              w_gnt0;
    logic              w_gnt1;
    m_req_t            w_new;
    logic              w_early;
    logic [CNT_W-1:0]  w_load;
    logic              w_m_valid;
    logic [XLEN-1:0]   w_m_result;
    logic              w_unused_tag;

    // Grant only from IDLE, never during reset or flush; tie goes to rr_ptr.
    assign w_can_grant = (r_state == ST_IDLE) & rst_n & ~flush;
    assign w_gnt0 = w_can_grant & bus.req0_valid & (~bus.req1_valid | ~r_rr_ptr);
    assign w_gnt1 = w_can_grant & bus.req1_valid & (~bus.req0_valid |  r_rr_ptr);

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;

    // Mux the granted requester into a request record.
    always_comb begin
        w_new = '0;
        if (w_gnt1) begin
            w_new.op  = bus.req1_op;
            w_new.a   = bus.req1_a;
            w_new.b   = bus.req1_b;
            w_new.tag = M_TAG_MAX_W'(bus.req1_tag);
            w_new.src = 1'b1;
        end else begin
            w_new.op  = bus.req0_op;
            w_new.a   = bus.req0_a;
            w_new.b   = bus.req0_b;
            w_new.tag = M_TAG_MAX_W'(bus.req0_tag);
            w_new.src = 1'b0;
        end
    end

`ifdef RV32_M_DIV_EARLY_OUT_EN
    // Divide-by-zero and signed overflow have constant results, so one cycle suffices.
    assign w_early = w_new.op[2] &
                     ((w_new.b == '0) |
                      (~w_new.op[0] & (w_new.a == 32'h8000_0000) & (w_new.b == 32'hFFFF_FFFF)));
`else
    assign w_early = 1'b0;
`endif

    assign w_load = ~w_new.op[2] ? MUL_LOAD : (w_early ? '0 : DIV_LOAD);

    // Operands reach the M unit only while executing.
    assign w_m_valid = (r_state == ST_EXEC);

    rv32_m_extension u_mext (
        .i_valid  (w_m_valid),
        .i_op     (r_req.op),
        .i_a      (r_req.a),
        .i_b      (r_req.b),
        .o_result (w_m_result)
    );

    // Upper tag bits beyond TAG_W are carried by the record but never returned.
    assign w_unused_tag = ^r_req.tag;

    // Sequencer: accept, hold operands LAT cycles, present result until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rr_ptr   <= 1'b0;
            r_req      <= '0;
            r_rsp_data <= '0;
            r_rsp_src  <= 1'b0;
            r_rsp_tag  <= '0;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt0 | w_gnt1) begin
                        r_req    <= w_new;
                        r_cnt    <= w_load;
                        r_rr_ptr <= ~w_new.src;
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == '0) begin
                        r_rsp_data <= w_m_result;
                        r_rsp_src  <= r_req.src;
                        r_rsp_tag  <= r_req.tag[TAG_W-1:0];
                        r_state    <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_src   = r_rsp_src;
    assign bus.rsp_tag   = r_rsp_tag;
    assign busy          = (r_state != ST_IDLE);

endmodule
